// File: rtl/quality_sorter_fsm_if.sv
// ---------------------------------------------------------------------------
// quality_sorter_fsm_if
// Bundles every item/result/status signal of the quality sorter so that the
// block and its environment connect through one port.
//   slave  : the sorter itself (takes items, drives grade/LEDs/counters)
//   master : the sensor front-end / status panel side
// Signal names keep the _i/_o suffix as seen from the sorter.
// ---------------------------------------------------------------------------
interface quality_sorter_fsm_if #(
    parameter int NUM_SENSORS = 3,
    parameter int CNT_W       = 8
);
    logic                   item_valid_i;
    logic                   item_ready_o;
    logic [NUM_SENSORS-1:0] sensor_i;
    logic                   cnt_clear_i;
    logic [1:0]             grade_o;
    logic                   grade_valid_o;
    logic                   timeout_o;
    logic                   led_reject_o;
    logic                   led_low_o;
    logic                   led_medium_o;
    logic                   led_high_o;
    logic [CNT_W-1:0]       cnt_high_o;
    logic [CNT_W-1:0]       cnt_medium_o;
    logic [CNT_W-1:0]       cnt_low_o;
    logic [CNT_W-1:0]       cnt_reject_o;
    logic [1:0]             current_state_o;

    modport slave (
        input  item_valid_i, sensor_i, cnt_clear_i,
        output item_ready_o, grade_o, grade_valid_o, timeout_o,
               led_reject_o, led_low_o, led_medium_o, led_high_o,
               cnt_high_o, cnt_medium_o, cnt_low_o, cnt_reject_o,
               current_state_o
    );

    modport master (
        output item_valid_i, sensor_i, cnt_clear_i,
        input  item_ready_o, grade_o, grade_valid_o, timeout_o,
               led_reject_o, led_low_o, led_medium_o, led_high_o,
               cnt_high_o, cnt_medium_o, cnt_low_o, cnt_reject_o,
               current_state_o
    );
endinterface

// File: rtl/quality_sorter_fsm.sv
// ---------------------------------------------------------------------------
// quality_sorter_fsm
// Item quality classifier: accepts an item, waits for the sensor vector to
// settle, grades it (reject/low/medium/high), lights one LED for HOLD_CYCLES
// and keeps saturating per-grade counters.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - quality_sorter_fsm_if.slave (item handshake, sensors, counter
//           clear, grade/timeout, LEDs, counters, state debug)
// ---------------------------------------------------------------------------
module quality_sorter_fsm #(
    parameter int NUM_SENSORS    = 3,
    parameter int SETTLE_CYCLES  = 2,
    parameter int SETTLE_TIMEOUT = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    quality_sorter_fsm_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TM_W = $clog2(SETTLE_TIMEOUT + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [ST_W-1:0]  STABLE_ONE  = ST_W'(1);
    localparam logic [ST_W-1:0]  STABLE_DONE = ST_W'(SETTLE_CYCLES);
    localparam logic [TM_W-1:0]  TMR_ONE     = TM_W'(1);
    localparam logic [TM_W-1:0]  TMR_DONE    = TM_W'(SETTLE_TIMEOUT);
    localparam logic [HD_W-1:0]  HOLD_ONE    = HD_W'(1);
    localparam logic [HD_W-1:0]  HOLD_LAST   = HD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]             state_q,   state_d;
    logic [NUM_SENSORS-1:0] snap_q,    snap_d;
    logic [ST_W-1:0]        stable_q,  stable_d;
    logic [ST_W-1:0]        stable_inc;
    logic [TM_W-1:0]        tmr_q,     tmr_d;
    logic                   force_q,   force_d;
    logic [1:0]             grade_q,   grade_d;
    logic                   timeout_q, timeout_d;
    logic [HD_W-1:0]        hold_q,    hold_d;
    logic [CNT_W-1:0]       cnt_q [4];
    logic [CNT_W-1:0]       cnt_d [4];
    logic                   cosmetic_ok;
    logic                   first_out;

    // With only weight/size sensors there is nothing cosmetic to fail,
    // so a heavy, right-sized item is always high grade.
    if (NUM_SENSORS > 2) begin : g_cosmetic
        assign cosmetic_ok = &snap_q[NUM_SENSORS-1:2];
    end else begin : g_no_cosmetic
        assign cosmetic_ok = 1'b1;
    end

    assign first_out = (state_q == S_OUTPUT) && (hold_q == '0);

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        stable_d   = stable_q;
        stable_inc = stable_q;
        tmr_d      = tmr_q;
        force_d    = force_q;
        grade_d    = grade_q;
        timeout_d  = timeout_q;
        hold_d     = hold_q;
        case (state_q)
            S_IDLE: begin
                if (bus.item_valid_i) begin
                    snap_d   = bus.sensor_i;
                    stable_d = STABLE_ONE;
                    tmr_d    = TMR_ONE;
                    force_d  = 1'b0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                tmr_d = tmr_q + TMR_ONE;
                if (bus.sensor_i == snap_q) begin
                    stable_inc = stable_q + STABLE_ONE;
                end else begin
                    snap_d     = bus.sensor_i;
                    stable_inc = STABLE_ONE;
                end
                stable_d = stable_inc;
                // Stability takes priority over the timeout in the same cycle.
                if (stable_inc == STABLE_DONE) begin
                    force_d = 1'b0;
                    state_d = S_EVAL;
                end else if (tmr_q == TMR_DONE) begin
                    force_d = 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (force_q || !snap_q[0]) begin
                    grade_d = 2'd0;
                end else if (!snap_q[1]) begin
                    grade_d = 2'd1;
                end else if (!cosmetic_ok) begin
                    grade_d = 2'd2;
                end else begin
                    grade_d = 2'd3;
                end
                timeout_d = force_q;
                hold_d    = '0;
                state_d   = S_OUTPUT;
            end
            default: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
        endcase
    end

    // Counter clear beats a same-cycle increment; counts stick at all-ones.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            cnt_d[g] = cnt_q[g];
            if (bus.cnt_clear_i) begin
                cnt_d[g] = '0;
            end else if (first_out && (grade_q == 2'(g)) && (cnt_q[g] != CNT_MAX)) begin
                cnt_d[g] = cnt_q[g] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            stable_q  <= '0;
            tmr_q     <= '0;
            force_q   <= 1'b0;
            grade_q   <= 2'd0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            for (int g = 0; g < 4; g++) begin
                cnt_q[g] <= '0;
            end
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            stable_q  <= stable_d;
            tmr_q     <= tmr_d;
            force_q   <= force_d;
            grade_q   <= grade_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            for (int g = 0; g < 4; g++) begin
                cnt_q[g] <= cnt_d[g];
            end
        end
    end

    assign bus.item_ready_o    = (state_q == S_IDLE);
    assign bus.grade_o         = grade_q;
    assign bus.timeout_o       = timeout_q;
    assign bus.grade_valid_o   = first_out;
    assign bus.led_reject_o    = (state_q == S_OUTPUT) && (grade_q == 2'd0);
    assign bus.led_low_o       = (state_q == S_OUTPUT) && (grade_q == 2'd1);
    assign bus.led_medium_o    = (state_q == S_OUTPUT) && (grade_q == 2'd2);
    assign bus.led_high_o      = (state_q == S_OUTPUT) && (grade_q == 2'd3);
    assign bus.cnt_reject_o    = cnt_q[0];
    assign bus.cnt_low_o       = cnt_q[1];
    assign bus.cnt_medium_o    = cnt_q[2];
    assign bus.cnt_high_o      = cnt_q[3];
    assign bus.current_state_o = state_q;
endmodule
